// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Handles one transaction at a time, alternates priority under contention and aborts on a stuck ack.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic              ls_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter value in the last cycle ACCESS may last before it is aborted.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic              owner_ls;
    logic              prio_ls;
    logic              result_ok;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;
    logic [7:0]        wait_cnt;
    logic              grant_ls;
    logic              timeout_hit;

    assign grant_ls    = ls_req && (!if_req || prio_ls);
    assign timeout_hit = (wait_cnt == LAST_CNT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (if_req || ls_req) state_next = ACCESS;
            ACCESS:  if (mem_ack || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner_ls   <= 1'b0;
            prio_ls    <= 1'b0;
            result_ok  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (if_req || ls_req) begin
                        owner_ls <= grant_ls;
                        we_q     <= grant_ls && ls_we;
                        addr_q   <= grant_ls ? ls_addr : if_addr;
                        wdata_q  <= grant_ls ? ls_wdata : '0;
                    end
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // An ack in the final allowed cycle still counts as success.
                    if (mem_ack) begin
                        result_ok <= 1'b1;
                        if (owner_ls) ls_rdata_q <= mem_rdata;
                        else          if_rdata_q <= mem_rdata;
                    end else if (timeout_hit) begin
                        result_ok <= 1'b0;
                    end
                end
                DONE: begin
                    prio_ls  <= !owner_ls;
                    wait_cnt <= '0;
                end
                default: wait_cnt <= '0;
            endcase
        end
    end

    assign mem_req   = (state == ACCESS);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q  : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign busy      = (state != IDLE);

    assign if_done   = (state == DONE) && !owner_ls &&  result_ok;
    assign if_err    = (state == DONE) && !owner_ls && !result_ok;
    assign ls_done   = (state == DONE) &&  owner_ls &&  result_ok;
    assign ls_err    = (state == DONE) &&  owner_ls && !result_ok;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, store, tie alternation, timeout, late ack and reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [7:0]  if_rdata;
    logic        if_done;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [7:0]  ls_wdata;
    logic [7:0]  ls_rdata;
    logic        ls_done;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_done(ls_done), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [47:0] got;
        rst = 1'b0; if_req = 0; ls_req = 0; ls_we = 0; mem_ack = 0;
        if_addr = 16'h1000; ls_addr = 16'h0; ls_wdata = 8'h0; mem_rdata = 8'h0;
        #2;
        got = {mem_req, mem_we, mem_addr, mem_wdata, if_done, if_err, ls_done, ls_err,
               busy, if_rdata, ls_rdata};
        vectors++;
        if (got !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        @(negedge clk); rst = 1'b1;
        step();
        vectors++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle busy=%b mem_req=%b exp=0/0", busy, mem_req);
        end
    endtask

    task automatic test_load();
        ls_req = 1; ls_we = 0; ls_addr = 16'h0040;
        step();
        vectors++;
        if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 16'h0040) begin
            miscompares++;
            $display("FAIL load_access req=%b we=%b addr=%h exp=1/0/0040", mem_req, mem_we, mem_addr);
        end
        step();
        vectors++;
        if (mem_req !== 1 || ls_done !== 0) begin
            miscompares++;
            $display("FAIL load_wait req=%b done=%b exp=1/0", mem_req, ls_done);
        end
        mem_ack = 1; mem_rdata = 8'hA5;
        step();
        mem_ack = 0; ls_req = 0;
        vectors++;
        if (ls_done !== 1 || ls_rdata !== 8'hA5 || mem_req !== 0 || ls_err !== 0) begin
            miscompares++;
            $display("FAIL load_done done=%b rdata=%h req=%b err=%b exp=1/a5/0/0",
                     ls_done, ls_rdata, mem_req, ls_err);
        end
        vectors++;
        if (if_done !== 0 || if_err !== 0 || if_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL load_if_quiet done=%b err=%b rdata=%h exp=0/0/00", if_done, if_err, if_rdata);
        end
        step();
        vectors++;
        if (ls_done !== 0 || busy !== 0) begin
            miscompares++;
            $display("FAIL load_single_pulse done=%b busy=%b exp=0/0", ls_done, busy);
        end
    endtask

    task automatic test_stray_ack();
        mem_ack = 1; mem_rdata = 8'hEE;
        step();
        mem_ack = 0;
        step();
        vectors++;
        if (busy !== 0 || ls_done !== 0 || if_done !== 0 || ls_rdata !== 8'hA5 || if_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL stray_ack busy=%b ls_done=%b if_done=%b ls_rdata=%h if_rdata=%h exp=0/0/0/a5/00",
                     busy, ls_done, if_done, ls_rdata, if_rdata);
        end
    endtask

    task automatic test_tie();
        logic [2:0]  exp_ls;
        logic [15:0] exp_addr;
        exp_ls = 3'b010;
        if_addr = 16'h1000; ls_addr = 16'h2000; ls_we = 0;
        if_req = 1; ls_req = 1;
        for (int i = 0; i < 3; i++) begin
            int w = 0;
            while (!mem_req && w < 10) begin
                step();
                w++;
            end
            exp_addr = exp_ls[i] ? 16'h2000 : 16'h1000;
            vectors++;
            if (mem_req !== 1 || mem_addr !== exp_addr) begin
                miscompares++;
                $display("FAIL tie_grant%0d req=%b addr=%h exp=1/%h", i, mem_req, mem_addr, exp_addr);
            end
            mem_ack = 1; mem_rdata = 8'h10 + 8'(i);
            step();
            mem_ack = 0;
            if (i == 2) begin
                if_req = 0; ls_req = 0;
            end
            vectors++;
            if (if_done !== !exp_ls[i] || ls_done !== exp_ls[i]) begin
                miscompares++;
                $display("FAIL tie_done%0d if_done=%b ls_done=%b exp=%b/%b",
                         i, if_done, ls_done, !exp_ls[i], exp_ls[i]);
            end
        end
        step();
    endtask

    task automatic test_store();
        ls_req = 1; ls_we = 1; ls_addr = 16'h1234; ls_wdata = 8'h3C;
        step();
        ls_addr = 16'hFFFF; ls_wdata = 8'h00; ls_we = 0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 16'h1234 || mem_wdata !== 8'h3C) begin
                miscompares++;
                $display("FAIL store_stable%0d req=%b we=%b addr=%h wdata=%h exp=1/1/1234/3c",
                         k, mem_req, mem_we, mem_addr, mem_wdata);
            end
            if (k == 2) mem_ack = 1;
            step();
        end
        mem_ack = 0; ls_req = 0;
        vectors++;
        if (ls_done !== 1 || mem_req !== 0 || mem_we !== 0) begin
            miscompares++;
            $display("FAIL store_done done=%b req=%b we=%b exp=1/0/0", ls_done, mem_req, mem_we);
        end
        step();
    endtask

    task automatic test_timeout();
        int cycles = 0;
        if_addr = 16'h0100;
        if_req = 1;
        step();
        mem_ack = 1; mem_rdata = 8'h5A;
        step();
        mem_ack = 0; if_req = 0;
        vectors++;
        if (if_done !== 1 || if_rdata !== 8'h5A) begin
            miscompares++;
            $display("FAIL timeout_setup done=%b rdata=%h exp=1/5a", if_done, if_rdata);
        end
        step();
        if_req = 1; mem_rdata = 8'h77;
        step();
        while (mem_req && cycles < 40) begin
            cycles++;
            step();
        end
        if_req = 0;
        vectors++;
        if (cycles !== 15) begin
            miscompares++;
            $display("FAIL timeout_len req_cycles=%0d exp=15", cycles);
        end
        vectors++;
        if (if_err !== 1 || if_done !== 0 || if_rdata !== 8'h5A || ls_err !== 0) begin
            miscompares++;
            $display("FAIL timeout_err err=%b done=%b rdata=%h ls_err=%b exp=1/0/5a/0",
                     if_err, if_done, if_rdata, ls_err);
        end
        step();
    endtask

    task automatic test_late_ack();
        if_req = 1;
        step();
        for (int k = 0; k < 14; k++) step();
        vectors++;
        if (mem_req !== 1) begin
            miscompares++;
            $display("FAIL late_ack_still_waiting req=%b exp=1", mem_req);
        end
        mem_ack = 1; mem_rdata = 8'hC3;
        step();
        mem_ack = 0; if_req = 0;
        vectors++;
        if (if_done !== 1 || if_err !== 0 || if_rdata !== 8'hC3) begin
            miscompares++;
            $display("FAIL late_ack done=%b err=%b rdata=%h exp=1/0/c3", if_done, if_err, if_rdata);
        end
        step();
    endtask

    task automatic test_reset_in_access();
        ls_req = 1; ls_we = 0; ls_addr = 16'h2000;
        step();
        vectors++;
        if (mem_req !== 1 || mem_addr !== 16'h2000) begin
            miscompares++;
            $display("FAIL rst_access_setup req=%b addr=%h exp=1/2000", mem_req, mem_addr);
        end
        rst = 0;
        #1;
        vectors++;
        if (mem_req !== 0 || busy !== 0 || if_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_access_drop req=%b busy=%b if_rdata=%h exp=0/0/00", mem_req, busy, if_rdata);
        end
        ls_req = 0;
        step();
        vectors++;
        if (ls_done !== 0 || ls_err !== 0 || if_done !== 0 || if_err !== 0) begin
            miscompares++;
            $display("FAIL rst_access_pulses ls=%b%b if=%b%b exp=00/00", ls_done, ls_err, if_done, if_err);
        end
        @(negedge clk); rst = 1;
        if_addr = 16'h1000; ls_addr = 16'h2000;
        if_req = 1; ls_req = 1;
        step();
        vectors++;
        if (mem_req !== 1 || mem_addr !== 16'h1000) begin
            miscompares++;
            $display("FAIL rst_prio_if req=%b addr=%h exp=1/1000", mem_req, mem_addr);
        end
        mem_ack = 1; mem_rdata = 8'h11;
        step();
        mem_ack = 0; if_req = 0; ls_req = 0;
        vectors++;
        if (if_done !== 1 || ls_done !== 0) begin
            miscompares++;
            $display("FAIL rst_prio_done if_done=%b ls_done=%b exp=1/0", if_done, ls_done);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_load();
        test_stray_ack();
        test_tie();
        test_store();
        test_timeout();
        test_late_ack();
        test_reset_in_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
